// File: rtl/fifo_wptr_full_if.sv
// Write-side signal bundle between the FIFO write logic and its write-domain user.
interface fifo_wptr_full_if #(
    parameter int unsigned ADDR_SIZE = 4
);
    logic                 winc;
    logic [ADDR_SIZE:0]   wq2_rptr;
    logic                 ovf_clr;
    logic                 wen;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 wfull;
    logic                 walmost_full;
    logic [ADDR_SIZE:0]   wlevel;
    logic                 wovf;

    // Writer side: issues requests, observes status.
    modport master (
        output winc, wq2_rptr, ovf_clr,
        input  wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );

    // Pointer/flag generator side.
    modport slave (
        input  winc, wq2_rptr, ovf_clr,
        output wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-domain pointer logic: binary RAM address, Gray pointer for the
// read domain, and full / almost-full / level / sticky overflow status derived from
// the synchronized read pointer.
module fifo_wptr_full #(
    parameter int unsigned ADDR_SIZE    = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input logic             clk,
    input logic             rst,
    fifo_wptr_full_if.slave wif
);
    localparam int unsigned PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic          r_wfull;
    logic          r_walmost_full;
    logic          r_wovf;
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_wlevel;

    logic          w_wen;
    logic          w_ovf_attempt;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic [PW-1:0] w_rptr_full;

    // A write is accepted only while not full; wfull is the registered flag, so a
    // full-to-not-full transition takes effect one cycle later.
    assign w_wen         = wif.winc & ~r_wfull;
    assign w_ovf_attempt = wif.winc & r_wfull;
    assign w_wbin_next   = r_wbin + PW'(w_wen);
    assign w_wgray_next  = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when the write pointer is exactly one lap ahead: in Gray code that is the
    // read pointer with its two MSBs inverted.
    assign w_rptr_full   = {~wif.wq2_rptr[ADDR_SIZE -: 2], wif.wq2_rptr[ADDR_SIZE-2:0]};

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            w_rbin[i] = ^(wif.wq2_rptr >> i);
        end
    end

    assign w_level_next = w_wbin_next - w_rbin;

    assign wif.wen          = w_wen;
    assign wif.waddr        = r_wbin[ADDR_SIZE-1:0];
    assign wif.wptr         = r_wptr;
    assign wif.wfull        = r_wfull;
    assign wif.walmost_full = r_walmost_full;
    assign wif.wlevel       = r_wlevel;
    assign wif.wovf         = r_wovf;

    // Pointer, status and overflow registers; overflow set takes priority over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_wovf         <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= (w_wgray_next == w_rptr_full);
            r_walmost_full <= (w_level_next >= AFULL_LVL);
            r_wlevel       <= w_level_next;
            if (w_ovf_attempt) begin
                r_wovf <= 1'b1;
            end else if (wif.ovf_clr) begin
                r_wovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: the driver pushes expected outputs computed
// from write/read counts; the monitor pops and compares once per cycle.
module tb_fifo_wptr_full;
    localparam int DEPTH = 16;
    localparam int PMOD  = 32;

    typedef struct {
        logic       wen;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       wafull;
        logic [4:0] wlevel;
        logic       wovf;
    } exp_t;

    logic clk;
    logic rst;
    fifo_wptr_full_if #(.ADDR_SIZE(4)) wif ();

    fifo_wptr_full #(.ADDR_SIZE(4), .AFULL_THRESH(12)) u_dut (
        .clk (clk),
        .rst (rst),
        .wif (wif)
    );

    exp_t q[$];
    int   n_tests  = 0;
    int   n_failed = 0;
    bit   done     = 0;
    bit   mon_done = 0;
    bit   first    = 1;

    // Reference state: total accepted writes, total reads seen, registered flags.
    int   m_wtot  = 0;
    int   rtot    = 0;
    bit   m_full  = 0;
    bit   m_afull = 0;
    bit   m_ovf   = 0;
    int   m_level = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b % PMOD);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; rtot must already hold the desired read count.
    task automatic drive(input bit r, input bit w, input bit clr);
        exp_t e;
        bit   acc;
        int   lvl;
        @(negedge clk);
        rst          = r;
        wif.winc     = w;
        wif.ovf_clr  = clr;
        wif.wq2_rptr = gray(rtot);
        e.wen    = w && !m_full;
        e.waddr  = 4'(m_wtot % DEPTH);
        e.wptr   = gray(m_wtot);
        e.wfull  = m_full;
        e.wafull = m_afull;
        e.wlevel = 5'(m_level);
        e.wovf   = m_ovf;
        if (!first) q.push_back(e);
        first = 0;
        if (r) begin
            m_wtot = 0; m_full = 0; m_afull = 0; m_ovf = 0; m_level = 0;
        end else begin
            acc = w && !m_full;
            if (w && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_wtot  = m_wtot + int'(acc);
            lvl     = ((m_wtot - rtot) % PMOD + PMOD) % PMOD;
            m_level = lvl;
            m_full  = (lvl == DEPTH);
            m_afull = (lvl >= 12);
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        while (!(done && q.size() == 0)) begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("wen",          8'(wif.wen),          8'(e.wen));
                check("waddr",        8'(wif.waddr),        8'(e.waddr));
                check("wptr",         8'(wif.wptr),         8'(e.wptr));
                check("wfull",        8'(wif.wfull),        8'(e.wfull));
                check("walmost_full", 8'(wif.walmost_full), 8'(e.wafull));
                check("wlevel",       8'(wif.wlevel),       8'(e.wlevel));
                check("wovf",         8'(wif.wovf),         8'(e.wovf));
            end
        end
        mon_done = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        bit w;
        rst = 1'b1;
        wif.winc = 1'b0;
        wif.ovf_clr = 1'b0;
        wif.wq2_rptr = '0;

        // Reset held with a pending write request.
        rtot = 0;
        repeat (3) drive(1, 1, 0);

        // Fill from empty, then overflow attempts and clear interplay.
        repeat (16) drive(0, 1, 0);
        repeat (2) drive(0, 1, 0);
        drive(0, 0, 1);
        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        drive(0, 0, 0);

        // Release by read pointer advance.
        rtot = 4;
        drive(0, 0, 0);
        rtot = 5;
        drive(0, 0, 0);
        drive(0, 0, 0);

        // Random traffic with a reader keeping the level at or below 8; wraps twice.
        for (int c = 0; c < 90; c++) begin
            w = ($urandom % 4) != 0;
            rtot = rtot + int'($urandom % 3);
            if (rtot > m_wtot) rtot = m_wtot;
            while ((m_wtot + int'(w && !m_full)) - rtot > 8) rtot++;
            drive(0, w, ($urandom % 16) == 0);
        end

        // Drain, refill to level 10, then reset mid-operation.
        rtot = m_wtot;
        drive(0, 0, 0);
        repeat (10) drive(0, 1, 0);
        rtot = 0;
        drive(1, 1, 0);
        repeat (3) drive(0, 1, 0);
        repeat (2) drive(0, 0, 0);

        done = 1;
        wait (mon_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side pointer and full-flag generator for the asynchronous FIFO, running entirely in the write clock domain.
- Accepts write requests and produces the binary RAM write address and RAM write enable.
- Produces the registered Gray-coded write pointer that is sent across to the read domain through the two-flop pointer synchronizer.
- Consumes the read Gray pointer after it has been synchronized into the write domain, and from it derives full, almost-full, fill level and a sticky overflow flag.

Parameters:
- ADDR_SIZE, 4, FIFO depth is 2^ADDR_SIZE. Pointers are ADDR_SIZE+1 bits. Legal range is ADDR_SIZE >= 2.
- AFULL_THRESH, 12, fill level at or above which walmost_full asserts. Legal range is 1..2^ADDR_SIZE.

Ports:
- clk  input  1  write-domain clock
- rst  input  1  synchronous, active-high reset
- winc  input  1  write request, sampled on the rising edge of clk
- wq2_rptr  input  ADDR_SIZE+1  read pointer, Gray-coded, already synchronized into the clk domain
- ovf_clr  input  1  clears wovf
- wen  output  1  RAM write enable (combinational)
- waddr  output  ADDR_SIZE  RAM write address
- wptr  output  ADDR_SIZE+1  registered Gray write pointer, sent to the synchronizer
- wfull  output  1  registered full flag
- walmost_full  output  1  registered almost-full flag
- wlevel  output  ADDR_SIZE+1  registered fill level, range 0..2^ADDR_SIZE
- wovf  output  1  sticky overflow flag

Behaviour:
Reset (rst=1 at a clk edge):
- wbin, wptr, wlevel, wfull, walmost_full and wovf all clear to 0 at that edge.
- Reset overrides every other input.
- The same rules apply when reset is asserted mid-operation: all state returns to 0 on the next edge, regardless of winc or wq2_rptr.

Accept and pointer update:
- wen = winc & ~wfull (combinational). This is the only condition under which a write is accepted.
- wbin_next = wbin + wen, computed modulo 2^(ADDR_SIZE+1). This gives natural wrap-around, and the MSB toggles once per lap.
- wgray_next = (wbin_next >> 1) ^ wbin_next.
- On each edge: wbin <= wbin_next and wptr <= wgray_next.
- waddr = wbin[ADDR_SIZE-1:0]. The write of the current cycle goes to waddr; the pointer advances at the edge.
- wptr changes by exactly one bit per accepted write and is glitch-free because it is registered.

Full flag:
- wfull <= (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
- Full asserts on the same edge that accepts the write filling the last slot.
- Full deasserts one edge after wq2_rptr advances.
- This is pessimistic but safe, given the additional synchronizer latency on the read pointer.

Level and almost-full:
- rbin is the Gray-to-binary conversion of wq2_rptr (XOR-prefix from the MSB down).
- wlevel <= (wbin_next - rbin) mod 2^(ADDR_SIZE+1).
- walmost_full <= (that same next level >= AFULL_THRESH).
- When full, the level equals 2^ADDR_SIZE.

Overflow:
- A write attempt while full is winc=1 & wfull=1.
- On such an attempt: wen=0, and the pointer, RAM and level are unchanged.
- wovf <= 1 on that edge.
- ovf_clr=1 clears wovf to 0 at the edge.
- If an overflow and ovf_clr occur in the same cycle, the set wins.

Other boundary rules:
- A simultaneous write and read advance in the same cycle uses both new values in that edge's computation. The level is unchanged when one write and one read step coincide.
- Full-to-not-full and a new write in the same cycle: wfull still gates that cycle's write. The write is accepted on the following cycle.

Test Plan:
1. Reset check:
   - Stimulus: drive winc=1 and hold rst=1 for 3 edges.
   - Required response: wptr=0, waddr=0, wlevel=0, wfull=0, wovf=0, wen=1, and no advance occurs.
2. Fill from empty (ADDR_SIZE=4, wq2_rptr=0):
   - Stimulus: 16 back-to-back writes.
   - Required response: wptr follows 1,3,2,6,… and reaches 5'b11000 (binary 16).
   - walmost_full rises on the edge where wlevel becomes 12.
   - wfull=1 after the 16th edge, with wlevel=16.
3. Overflow:
   - Stimulus: while full, winc=1 for 2 cycles.
   - Required response: wen=0, wptr holds at 5'b11000, wovf=1 and stays 1.
   - ovf_clr pulse: wovf=0 on the next edge.
   - ovf_clr concurrent with a further overflow: wovf remains 1.
4. Release:
   - Stimulus: with the FIFO full, set wq2_rptr=5'b00110 (binary 4).
   - Required response: wfull=0 and wlevel=12 one edge later, with walmost_full still 1.
   - Then set wq2_rptr=gray(5): walmost_full=0 and wlevel=11.
5. Wrap-around:
   - Stimulus: 40 writes, with a reader model advancing wq2_rptr to keep the level at or below 8.
   - Required response: binary pointer 31→0 wraps with the MSB toggling, and wptr 5'b10000→5'b00000.
   - wfull never asserts, and wlevel matches the scoreboard every cycle.
6. Mid-operation reset:
   - Stimulus: at level 10, assert rst for one edge while winc=1.
   - Required response: all outputs return to 0. The first write after release goes to waddr=0.
